// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: frame classification and key legend.
package keypad_pkg;

   // What a completed scan frame contained.
   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_MULTI  = 2'd2
   } cls_t;

   // Map a 4x4 index (row*4+col) to the hex legend printed on the Pmod KYPD.
   function automatic logic [3:0] hex_legend(input logic [3:0] idx);
      logic [3:0] legend;
      case (idx)
         4'd0:    legend = 4'h1;
         4'd1:    legend = 4'h2;
         4'd2:    legend = 4'h3;
         4'd3:    legend = 4'hA;
         4'd4:    legend = 4'h4;
         4'd5:    legend = 4'h5;
         4'd6:    legend = 4'h6;
         4'd7:    legend = 4'hB;
         4'd8:    legend = 4'h7;
         4'd9:    legend = 4'h8;
         4'd10:   legend = 4'h9;
         4'd11:   legend = 4'hC;
         4'd12:   legend = 4'h0;
         4'd13:   legend = 4'hF;
         4'd14:   legend = 4'hE;
         default: legend = 4'hD;
      endcase
      return legend;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: compares successive frame classifications, counts
// stable frames and commits a new key state with press/release pulses.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int KW       = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_end,
   input  cls_t          cls,
   input  logic [KW-1:0] cls_idx,
   output logic [KW-1:0] key,
   output logic          key_valid,
   output logic          key_press,
   output logic          key_release,
   output logic          multi
);

   localparam int CNTW = $clog2(DEBOUNCE + 1);
   localparam logic [CNTW-1:0] DB_MAX = CNTW'(DEBOUNCE);

   cls_t            prev_cls_reg, prev_cls_next;
   logic [KW-1:0]   prev_idx_reg, prev_idx_next;
   logic [CNTW-1:0] cnt_reg, cnt_next;
   cls_t            commit_cls_reg, commit_cls_next;
   logic [KW-1:0]   commit_idx_reg, commit_idx_next;
   logic            press_reg, press_next;
   logic            release_reg, release_next;
   logic            same_as_prev;
   logic            differs_from_commit;

   // State register; reset leaves nothing committed and no pulse pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_cls_reg   <= CLS_NONE;
         prev_idx_reg   <= '0;
         cnt_reg        <= '0;
         commit_cls_reg <= CLS_NONE;
         commit_idx_reg <= '0;
         press_reg      <= 1'b0;
         release_reg    <= 1'b0;
      end else begin
         prev_cls_reg   <= prev_cls_next;
         prev_idx_reg   <= prev_idx_next;
         cnt_reg        <= cnt_next;
         commit_cls_reg <= commit_cls_next;
         commit_idx_reg <= commit_idx_next;
         press_reg      <= press_next;
         release_reg    <= release_next;
      end
   end

   // On each frame end: update stable count and commit when stable and changed.
   always_comb begin
      prev_cls_next       = prev_cls_reg;
      prev_idx_next       = prev_idx_reg;
      cnt_next            = cnt_reg;
      commit_cls_next     = commit_cls_reg;
      commit_idx_next     = commit_idx_reg;
      press_next          = 1'b0;
      release_next        = 1'b0;
      same_as_prev        = (cls == prev_cls_reg) &&
                            ((cls != CLS_SINGLE) || (cls_idx == prev_idx_reg));
      differs_from_commit = (cls != commit_cls_reg) ||
                            ((cls == CLS_SINGLE) && (cls_idx != commit_idx_reg));
      if (frame_end) begin
         prev_cls_next = cls;
         prev_idx_next = cls_idx;
         if (same_as_prev)
            cnt_next = (cnt_reg == DB_MAX) ? cnt_reg : cnt_reg + CNTW'(1);
         else
            cnt_next = CNTW'(1);
         if ((cnt_next == DB_MAX) && differs_from_commit) begin
            commit_cls_next = cls;
            if (cls == CLS_SINGLE) begin
               // key only moves on a single-key commit, so it holds across release
               commit_idx_next = cls_idx;
               press_next      = 1'b1;
            end else if (commit_cls_reg == CLS_SINGLE) begin
               release_next = 1'b1;
            end
         end
      end
   end

   assign key         = commit_idx_reg;
   assign key_valid   = (commit_cls_reg == CLS_SINGLE);
   assign multi       = (commit_cls_reg == CLS_MULTI);
   assign key_press   = press_reg;
   assign key_release = release_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one-cold columns, samples synchronised rows
// into a frame bitmap and hands each finished frame to the debouncer.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter  int ROWS         = 4,
   parameter  int COLS         = 4,
   parameter  int COL_TICKS    = 100000,
   parameter  int SETTLE_TICKS = 100,
   parameter  int DEBOUNCE     = 3,
   localparam int KW           = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic [KW-1:0]   key,
   output logic            key_valid,
   output logic            key_press,
   output logic            key_release,
   output logic            multi
);

   localparam int NB = ROWS * COLS;
   localparam int TW = $clog2(COL_TICKS);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic [ROWS-1:0] row_s1_reg, row_s2_reg;
   logic            started_reg;
   logic [TW-1:0]   tick_reg, tick_next;
   logic [CW-1:0]   col_idx_reg, col_idx_next;
   logic [COLS-1:0] col_reg, col_next;
   logic [NB-1:0]   bitmap_reg, bitmap_next;
   logic            frame_end;
   logic            sample;
   logic [KW-1:0]   bit_idx;
   logic            found, many;
   logic [KW-1:0]   cls_idx;
   cls_t            cls;

   assign frame_end = started_reg && (tick_reg == TW'(COL_TICKS - 1)) &&
                      (col_idx_reg == CW'(COLS - 1));
   assign sample    = started_reg && (tick_reg == TW'(SETTLE_TICKS));

   // Two-flop row synchroniser plus scan counters and column drive register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1_reg  <= '1;
         row_s2_reg  <= '1;
         started_reg <= 1'b0;
         tick_reg    <= '0;
         col_idx_reg <= '0;
         col_reg     <= '1;
         bitmap_reg  <= '0;
      end else begin
         row_s1_reg  <= row;
         row_s2_reg  <= row_s1_reg;
         started_reg <= 1'b1;
         tick_reg    <= tick_next;
         col_idx_reg <= col_idx_next;
         col_reg     <= col_next;
         bitmap_reg  <= bitmap_next;
      end
   end

   // Slot timing; the first edge after reset only starts slot 0 at tick 0.
   always_comb begin
      tick_next    = '0;
      col_idx_next = '0;
      if (started_reg) begin
         tick_next    = tick_reg + TW'(1);
         col_idx_next = col_idx_reg;
         if (tick_reg == TW'(COL_TICKS - 1)) begin
            tick_next    = '0;
            col_idx_next = (col_idx_reg == CW'(COLS - 1)) ? '0 : col_idx_reg + CW'(1);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < COLS; gi++) begin : g_col
         assign col_next[gi] = (col_idx_next != CW'(gi));
      end
   endgenerate

   // Capture the active column's rows at the settle tick; clear at frame end.
   always_comb begin
      bitmap_next = bitmap_reg;
      bit_idx     = '0;
      if (frame_end) begin
         bitmap_next = '0;
      end else if (sample) begin
         for (int r = 0; r < ROWS; r++) begin
            bit_idx              = KW'(r * COLS) + KW'(col_idx_reg);
            bitmap_next[bit_idx] = ~row_s2_reg[r];
         end
      end
   end

   // Classify the bitmap as none, one key (with its index) or several keys.
   always_comb begin
      found   = 1'b0;
      many    = 1'b0;
      cls_idx = '0;
      for (int i = 0; i < NB; i++) begin
         if (bitmap_reg[i]) begin
            if (found) begin
               many = 1'b1;
            end else begin
               found   = 1'b1;
               cls_idx = KW'(i);
            end
         end
      end
      cls = many ? CLS_MULTI : (found ? CLS_SINGLE : CLS_NONE);
   end

   assign col = col_reg;

   keypad_debounce #(
      .KW       (KW),
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .frame_end   (frame_end),
      .cls         (cls),
      .cls_idx     (cls_idx),
      .key         (key),
      .key_valid   (key_valid),
      .key_press   (key_press),
      .key_release (key_release),
      .multi       (multi)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus queues expected press/release
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int FRAME = 64;   // 4 columns x 16 ticks

   typedef struct {
      bit         is_press;
      logic [3:0] key;
      bit         valid;
      bit         mult;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       key_valid, key_press, key_release, multi;
   logic [15:0] keys = '0;

   int  cyc = 0;
   int  n_vec = 0;
   int  n_miss = 0;
   ev_t exp_q[$];

   keypad_scanner #(
      .ROWS(4), .COLS(4), .COL_TICKS(16), .SETTLE_TICKS(4), .DEBOUNCE(3)
   ) dut (
      .clk(clk), .rst(rst), .row(row), .col(col), .key(key),
      .key_valid(key_valid), .key_press(key_press),
      .key_release(key_release), .multi(multi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Keypad model: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      for (int r = 0; r < 4; r++)
         row[r] = ~|(keys[r*4 +: 4] & ~col);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit is_press, input int k, input bit v, input bit m, input int c);
      ev_t e;
      e.is_press = is_press; e.key = 4'(k); e.valid = v; e.mult = m; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // Return the cycle of the next negedge where column 0 has just become active.
   task automatic wait_frame(output int s);
      logic [3:0] last;
      bit         hit;
      last = col;
      hit  = 1'b0;
      s    = cyc;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (col == 4'b1110 && last != 4'b1110) begin
            hit = 1'b1;
            s   = cyc;
         end
         last = col;
      end
      if (!hit) chk("frame_start_timeout", 0, 1);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: every pulse must match the head of the expected queue.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (key_press && key_release) chk("press_and_release", 1, 0);
         if (key_press || key_release) begin
            $display("event %s key=%0d valid=%0b multi=%0b cyc=%0d",
                     key_press ? "press" : "release", key, key_valid, multi, cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ev_kind",  int'(key_press), int'(e.is_press));
               chk("ev_key",   int'(key),       int'(e.key));
               chk("ev_valid", int'(key_valid), int'(e.valid));
               chk("ev_multi", int'(multi),     int'(e.mult));
               chk("ev_cycle", cyc,             e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int e;
      logic [3:0] exp_col;

      chk("legend_0",  int'(hex_legend(4'd0)),  1);
      chk("legend_3",  int'(hex_legend(4'd3)),  10);
      chk("legend_15", int'(hex_legend(4'd15)), 13);

      // Reset state, then the idle column scan.
      repeat (3) @(negedge clk);
      chk("rst_col",   int'(col), 15);
      chk("rst_key",   int'(key), 0);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_multi", int'(multi), 0);
      rst = 1'b0;
      e = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((i / 16) % 4));
         if (col !== exp_col || key_valid !== 1'b0 || multi !== 1'b0) e++;
      end
      chk("idle_scan_errors", e, 0);
      $display("idle scan checked for %0d cycles", 2 * FRAME);

      // Single key (row 1, col 2) held for 5 frames.
      wait_frame(s);
      keys = 16'h0040;
      push(1'b1, 6, 1'b1, 1'b0, s + 3 * FRAME);
      wait_until(s + 3 * FRAME - 1);
      chk("pre_press_valid", int'(key_valid), 0);
      repeat (5) wait_frame(s);
      chk("held_key", int'(key), 6);
      chk("held_valid", int'(key_valid), 1);
      chk("held_multi", int'(multi), 0);

      // Release: three empty frames later.
      keys = 16'h0000;
      push(1'b0, 6, 1'b0, 1'b0, s + 3 * FRAME);
      repeat (4) wait_frame(s);
      chk("rel_valid", int'(key_valid), 0);
      chk("rel_key", int'(key), 6);

      // Bouncing key present only in alternate frames.
      for (int f = 0; f < 8; f++) begin
         keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
         wait_frame(s);
      end
      keys = 16'h0000;
      repeat (2) wait_frame(s);
      chk("bounce_valid", int'(key_valid), 0);

      // Two keys (0,0) and (2,3): multi commits with no pulses.
      keys = 16'h0801;
      wait_until(s + 3 * FRAME - 1);
      chk("multi_before", int'(multi), 0);
      wait_until(s + 3 * FRAME);
      chk("multi_after", int'(multi), 1);
      chk("multi_valid", int'(key_valid), 0);
      wait_frame(s);
      keys = 16'h0000;
      repeat (4) wait_frame(s);
      chk("multi_cleared", int'(multi), 0);

      // Direct switch from one single key to another.
      keys = 16'h0040;
      push(1'b1, 6, 1'b1, 1'b0, s + 3 * FRAME);
      repeat (3) wait_frame(s);
      keys = 16'h8000;
      push(1'b1, 15, 1'b1, 1'b0, s + 3 * FRAME);
      repeat (4) wait_frame(s);
      chk("switch_key", int'(key), 15);
      chk("switch_valid", int'(key_valid), 1);

      // Asynchronous reset mid-cycle while a key is committed.
      #2;
      rst  = 1'b1;
      keys = 16'h0000;
      #1;
      chk("arst_col",     int'(col), 15);
      chk("arst_key",     int'(key), 0);
      chk("arst_valid",   int'(key_valid), 0);
      chk("arst_press",   int'(key_press), 0);
      chk("arst_release", int'(key_release), 0);
      chk("arst_multi",   int'(multi), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) wait_frame(s);
      chk("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
